// File: rtl/divider_pkg.sv
// Shared timing constants for the clock-divider family and the DIV legality rule.
// Every timing block derives its default division ratio from CLK_HZ / OUT_HZ here.
package divider_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int OUT_HZ      = 1;
    localparam int DIV_DEFAULT = CLK_HZ / OUT_HZ;

    // A 50 % duty output needs an even ratio of at least one CLK per phase.
    function automatic bit div_is_legal(input int div);
        return (div >= 2) && ((div % 2) == 0);
    endfunction

endpackage

// File: rtl/divider.sv
// Divide CLK by DIV: secCLK is a flop-driven 50 % square wave, and tick pulses for one CLK
// as secCLK rises. EN stalls the counter. Constrain as generated clock: CLK / DIV.
module divider
    import divider_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = $clog2(DIV / 2)
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic EN,
    output logic secCLK,
    output logic tick
);

    // DIV=2 gives a zero-width half-period counter; keep one bit so the flop is legal.
    localparam int              CW   = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0]   LAST = CW'(DIV / 2 - 1);

    if (!div_is_legal(DIV)) begin : g_bad_div
        $error("divider: DIV=%0d must be even and >= 2", DIV);
    end

    if (CNT_W < $clog2(DIV / 2)) begin : g_bad_cnt_w
        $error("divider: CNT_W=%0d too narrow for DIV=%0d", CNT_W, DIV);
    end

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = EN && (cnt == LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (EN) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // tick is set on the same edge that raises secCLK, so it overlaps secCLK's first high cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            secCLK <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= wrap && !secCLK;
            if (wrap) begin
                secCLK <= ~secCLK;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider at DIV = 4, 1000, 8 and 2 with hand-derived edge tables.
module tb_divider;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    logic rst_a, en_a, sec_a, tk_a;   // DIV=4
    logic rst_b, en_b, sec_b, tk_b;   // DIV=1000
    logic rst_c, en_c, sec_c, tk_c;   // DIV=8
    logic rst_d, en_d, sec_d, tk_d;   // DIV=2

    divider #(.DIV(4))    u_a (.CLK(CLK), .RESET_N(rst_a), .EN(en_a), .secCLK(sec_a), .tick(tk_a));
    divider #(.DIV(1000)) u_b (.CLK(CLK), .RESET_N(rst_b), .EN(en_b), .secCLK(sec_b), .tick(tk_b));
    divider #(.DIV(8))    u_c (.CLK(CLK), .RESET_N(rst_c), .EN(en_c), .secCLK(sec_c), .tick(tk_c));
    divider #(.DIV(2))    u_d (.CLK(CLK), .RESET_N(rst_d), .EN(en_d), .secCLK(sec_d), .tick(tk_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int a_sec [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int a_tick[8] = '{0, 1, 0, 0, 0, 1, 0, 0};

    initial begin
        int   rises, ticks, bad_align, last_toggle, hi_len, lo_len;
        logic prev;

        {rst_a, rst_b, rst_c, rst_d} = 4'b1111;
        {en_a, en_b, en_c, en_d}     = 4'b1111;
        #1;
        {rst_a, rst_b, rst_c, rst_d} = 4'b0000;
        #1;
        chk("reset_sec_a", sec_a, 0); chk("reset_tick_a", tk_a, 0);
        chk("reset_sec_b", sec_b, 0); chk("reset_tick_b", tk_b, 0);
        chk("reset_sec_c", sec_c, 0); chk("reset_tick_c", tk_c, 0);
        chk("reset_sec_d", sec_d, 0); chk("reset_tick_d", tk_d, 0);
        step();
        step();

        // DIV=4: rise at edge 2, fall at 4, rise at 6
        rst_a = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("div4_sec_e%0d", e), sec_a, a_sec[e-1]);
            chk($sformatf("div4_tick_e%0d", e), tk_a, a_tick[e-1]);
        end

        // DIV=1000 over 5000 cycles: five rises, every phase 500 cycles
        rst_b       = 1'b1;
        prev        = 1'b0;
        rises       = 0;
        ticks       = 0;
        bad_align   = 0;
        last_toggle = 0;
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            step();
            if (sec_b !== prev) begin
                if (last_toggle == 0) chk("div1000_first_rise", cyc, 500);
                else                  chk($sformatf("div1000_phase_at_%0d", cyc), cyc - last_toggle, 500);
                last_toggle = cyc;
                if (sec_b) rises++;
            end
            if (tk_b !== (sec_b && !prev)) bad_align++;
            if (tk_b) ticks++;
            prev = sec_b;
        end
        chk("div1000_rises", rises, 5);
        chk("div1000_ticks", ticks, 5);
        chk("div1000_tick_align", bad_align, 0);

        // DIV=8 with EN low for edges 6..8 inside the first high phase
        rst_c  = 1'b1;
        hi_len = 0;
        lo_len = 0;
        for (int e = 1; e <= 15; e++) begin
            en_c = (e >= 6 && e <= 8) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("div8_sec_e%0d", e), sec_c, (e >= 4 && e <= 10) || e == 15);
            chk($sformatf("div8_tick_e%0d", e), tk_c, e == 4 || e == 15);
            if (e >= 4 && e <= 14) begin
                if (sec_c) hi_len++;
                else       lo_len++;
            end
        end
        chk("div8_stalled_high_len", hi_len, 7);
        chk("div8_next_low_len", lo_len, 4);

        // async reset mid-cycle while secCLK=1 and tick=1
        en_c = 1'b1;
        #2;
        rst_c = 1'b0;
        #1;
        chk("div8_async_sec", sec_c, 0);
        chk("div8_async_tick", tk_c, 0);
        step();
        chk("div8_held_sec", sec_c, 0);
        chk("div8_held_tick", tk_c, 0);
        rst_c = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk($sformatf("div8_rel_sec_e%0d", e), sec_c, e >= 4);
            chk($sformatf("div8_rel_tick_e%0d", e), tk_c, e == 4);
        end

        // DIV=2: toggle every enabled cycle, tick on the rising ones
        rst_d = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("div2_sec_e%0d", e), sec_d, e % 2);
            chk($sformatf("div2_tick_e%0d", e), tk_d, e % 2);
        end
        en_d = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            step();
            chk($sformatf("div2_stall_sec_%0d", e), sec_d, 0);
            chk($sformatf("div2_stall_tick_%0d", e), tk_d, 0);
        end
        en_d = 1'b1;
        step();
        chk("div2_resume_sec", sec_d, 1);
        chk("div2_resume_tick", tk_d, 1);
        step();
        chk("div2_resume_sec2", sec_d, 0);
        chk("div2_resume_tick2", tk_d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
